// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// optional rotation, serial in/out on both ends, plus a multi-step shift
// engine that runs a requested number of shifts and reports busy/done.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_RIGHT = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [AMT_W-1:0] rem, rem_nx;     // shifts still owed while BUSY
  logic             dir_left, dir_left_nx;
  logic             rot_lat, rot_lat_nx;

  // One shift step; serial inputs are always the live pins.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic left,
                                              input logic rot,
                                              input logic sr,
                                              input logic sl);
    if (left) shift1 = {v[WIDTH-2:0], rot ? v[WIDTH-1] : sl};
    else      shift1 = {rot ? v[0] : sr, v[WIDTH-1:1]};
  endfunction

  // Next-state, next-data and latched-request logic.
  always_comb begin
    state_nx    = state;
    q_nx        = q;
    rem_nx      = rem;
    dir_left_nx = dir_left;
    rot_lat_nx  = rot_lat;
    case (state)
      IDLE: begin
        if (start && (mode == M_RIGHT || mode == M_LEFT)) begin
          // Accepting edge: latch direction/rotate, first shift happens now.
          dir_left_nx = mode[1];
          rot_lat_nx  = rotate;
          if (amount == '0) begin
            state_nx = DONE;
          end else begin
            q_nx     = shift1(q, mode[1], rotate, ser_in_r, ser_in_l);
            rem_nx   = amount - AMT_W'(1);
            state_nx = (amount == AMT_W'(1)) ? DONE : BUSY;
          end
        end else begin
          case (mode)
            M_RIGHT: q_nx = shift1(q, 1'b0, rotate, ser_in_r, ser_in_l);
            M_LEFT:  q_nx = shift1(q, 1'b1, rotate, ser_in_r, ser_in_l);
            M_LOAD:  q_nx = par_in;
            default: q_nx = q;  // M_HOLD
          endcase
        end
      end
      BUSY: begin
        // Live mode/rotate/amount/start are ignored until the run ends.
        q_nx   = shift1(q, dir_left, rot_lat, ser_in_r, ser_in_l);
        rem_nx = rem - AMT_W'(1);
        if (rem == AMT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      rem      <= '0;
      dir_left <= 1'b0;
      rot_lat  <= 1'b0;
    end else begin
      state    <= state_nx;
      q        <= q_nx;
      rem      <= rem_nx;
      dir_left <= dir_left_nx;
      rot_lat  <= rot_lat_nx;
    end
  end

  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];
  assign busy      = (state == BUSY);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus a random
// run compared against an arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          rotate, ser_in_r, ser_in_l, start;
  logic [W-1:0]  par_in;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          ser_out_r, ser_out_l, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: value as an integer, shifts still owed, done pulse.
  int m_q, m_owed;
  bit m_done, m_left, m_rot;

  univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .rotate(rotate),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .par_in(par_in),
    .start(start), .amount(amount), .q(q), .ser_out_r(ser_out_r),
    .ser_out_l(ser_out_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int shf(int v, bit left, bit rot);
    int b;
    if (!left) begin
      b = rot ? v % 2 : int'(ser_in_r);
      return v / 2 + b * HALF;
    end
    b = rot ? v / HALF : int'(ser_in_l);
    return (v * 2) % FULL + b;
  endfunction

  task automatic model_reset();
    m_q = 0; m_owed = 0; m_done = 0; m_left = 0; m_rot = 0;
  endtask

  task automatic model_edge();
    if (m_done) m_done = 0;
    else if (m_owed > 0) begin
      m_q = shf(m_q, m_left, m_rot);
      m_owed--;
      if (m_owed == 0) m_done = 1;
    end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
      m_left = (mode == 2'd2);
      m_rot  = rotate;
      if (amount == 0) m_done = 1;
      else begin
        m_q    = shf(m_q, m_left, m_rot);
        m_owed = int'(amount) - 1;
        if (m_owed == 0) m_done = 1;
      end
    end else begin
      case (mode)
        2'd1: m_q = shf(m_q, 0, rotate);
        2'd2: m_q = shf(m_q, 1, rotate);
        2'd3: m_q = int'(par_in);
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    start = 0; mode = 2'd3; par_in = v;
    tick();
    mode = 2'd0;
  endtask

  task automatic test_reset();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_init q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
    end
    load(8'hFF);
    checks++;
    if (q !== 8'hFF) begin errors++; $display("FAIL load_ff q=%h exp ff", q); end
    #3 rst = 1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_async q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
    end
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_single();
    load(8'hA5);
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL load_a5 q=%h exp a5", q); end
    mode = 2'd1; rotate = 0; ser_in_r = 1;
    tick();
    checks++;
    if (q !== 8'hD2 || ser_out_r !== 1'b0 || ser_out_l !== 1'b1) begin
      errors++; $display("FAIL single_right q=%h sor=%b sol=%b exp d2/0/1", q, ser_out_r, ser_out_l);
    end
    mode = 2'd2; ser_in_l = 0;
    tick();
    checks++;
    if (q !== 8'hA4 || done !== 1'b0) begin
      errors++; $display("FAIL single_left q=%h done=%b exp a4/0", q, done);
    end
    mode = 2'd0;
  endtask

  task automatic test_multi_rotate();
    logic [W-1:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    load(8'h81);
    start = 1; mode = 2'd2; rotate = 1; amount = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 0; mode = 2'd0; rotate = 0;
      checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errors++;
        $display("FAIL multi_rot step%0d q=%h busy=%b done=%b exp %h/%b/%b",
                 i, q, busy, done, exp_q[i], i < 2, i == 2);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h0C) begin
      errors++; $display("FAIL multi_rot_end q=%h busy=%b done=%b exp 0c/0/0", q, busy, done);
    end
  endtask

  task automatic test_full_rotate_overshoot();
    load(8'h3C);
    start = 1; mode = 2'd1; rotate = 1; amount = 4'd8;
    tick();
    start = 0; mode = 2'd0; rotate = 0;
    for (int i = 1; i < 8; i++) tick();
    checks++;
    if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rot_full q=%h done=%b busy=%b exp 3c/1/0", q, done, busy);
    end
    tick();
    load(8'hA5);
    start = 1; mode = 2'd1; rotate = 0; amount = 4'd10; ser_in_r = 0;
    tick();
    start = 0; mode = 2'd0;
    for (int i = 1; i < 10; i++) tick();
    checks++;
    if (q !== 8'h00 || done !== 1'b1) begin
      errors++; $display("FAIL overshoot q=%h done=%b exp 00/1", q, done);
    end
    tick();
  endtask

  task automatic test_ignored();
    load(8'h5A);
    start = 1; mode = 2'd1; rotate = 0; amount = 4'd0;
    tick();
    start = 0; mode = 2'd0;
    checks++;
    if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL amt0 q=%h done=%b busy=%b exp 5a/1/0", q, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL amt0_pulse done=%b exp 0", done); end
    start = 1; mode = 2'd3; par_in = 8'h33; amount = 4'd2;
    tick();
    start = 0; mode = 2'd0;
    checks++;
    if (q !== 8'h33 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_load q=%h done=%b busy=%b exp 33/0/0", q, done, busy);
    end
    load(8'h01);
    start = 1; mode = 2'd2; rotate = 0; ser_in_l = 0; amount = 4'd4;
    tick();
    // Disturb live controls while the run is in flight; keep start high.
    mode = 2'd1; rotate = 1; amount = 4'd1;
    tick(); tick(); tick();
    checks++;
    if (q !== 8'h10 || done !== 1'b1) begin
      errors++; $display("FAIL busy_ignore q=%h done=%b exp 10/1", q, done);
    end
    tick();
    checks++;
    if (q !== 8'h10 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_holds q=%h done=%b busy=%b exp 10/0/0", q, done, busy);
    end
    tick();
    start = 0; mode = 2'd0; rotate = 0;
    checks++;
    if (q !== 8'h08 || done !== 1'b1) begin
      errors++; $display("FAIL reaccept q=%h done=%b exp 08/1", q, done);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    load(8'hF0);
    start = 1; mode = 2'd1; rotate = 0; ser_in_r = 0; amount = 4'd5;
    tick();
    start = 0; mode = 2'd0;
    tick();
    checks++;
    if (q !== 8'h3C || busy !== 1'b1) begin
      errors++; $display("FAIL midop_pre q=%h busy=%b exp 3c/1", q, busy);
    end
    #3 rst = 1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midop_rst q=%h busy=%b done=%b exp 00/0/0", q, busy, done);
    end
    #1 rst = 0;
    model_reset();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midop_nodone busy=%b done=%b exp 0/0", busy, done);
    end
    start = 1; mode = 2'd2; ser_in_l = 1; amount = 4'd1;
    tick();
    start = 0; mode = 2'd0;
    checks++;
    if (q !== 8'h01 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midop_after q=%h done=%b busy=%b exp 01/1/0", q, done, busy);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mode     = 2'($urandom_range(0, 3));
      rotate   = 1'($urandom_range(0, 1));
      ser_in_r = 1'($urandom_range(0, 1));
      ser_in_l = 1'($urandom_range(0, 1));
      par_in   = 8'($urandom);
      start    = ($urandom_range(0, 2) == 0);
      amount   = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (q !== W'(m_q) || busy !== (m_owed > 0) || done !== m_done ||
          ser_out_r !== q[0] || ser_out_l !== q[W-1]) begin
        errors++;
        $display("FAIL random%0d q=%h busy=%b done=%b sor=%b sol=%b exp q=%h busy=%b done=%b",
                 i, q, busy, done, ser_out_r, ser_out_l, W'(m_q), m_owed > 0, m_done);
      end
    end
    start = 0; mode = 2'd0;
  endtask

  initial begin
    rst = 1; mode = 0; rotate = 0; ser_in_r = 0; ser_in_l = 0;
    par_in = 0; start = 0; amount = 0;
    model_reset();
    #12 rst = 0;
    test_reset();
    test_single();
    test_multi_rotate();
    test_full_rotate_overshoot();
    test_ignored();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
